// File: rtl/i2s_rx_deserializer_if.sv
// Signal bundle between the I2S slave receiver, the external I2S pins and the
// write side of the stereo sample FIFO.
interface i2s_rx_deserializer_if #(
    parameter int unsigned WORDSIZE   = 32,
    parameter int unsigned DROP_CNT_W = 16
);
    logic                  enable;
    logic                  i2s_bclk;
    logic                  i2s_lrclk;
    logic                  i2s_sdata;
    logic                  fifo_full;
    logic                  write_en;
    logic [WORDSIZE-1:0]   data_left_out;
    logic [WORDSIZE-1:0]   data_right_out;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;
    logic                  locked;

    modport master (
        output enable, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_full,
        input  write_en, data_left_out, data_right_out, overflow, drop_count, locked
    );

    modport slave (
        input  enable, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_full,
        output write_en, data_left_out, data_right_out, overflow, drop_count, locked
    );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Slave I2S receiver: oversamples BCLK/LRCLK/SDATA, deserializes MSB-first
// left/right words and pushes each complete pair into the sample FIFO.
module i2s_rx_deserializer #(
    parameter int unsigned WORDSIZE   = 32,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    i2s_rx_deserializer_if.slave  bus
);
    localparam int unsigned      CNT_W   = $clog2(WORDSIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDSIZE);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_e;

    state_e                state_q, state_d;
    logic                  bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic                  lr_s1_q, lr_s2_q;
    logic                  sd_s1_q, sd_s2_q;
    logic                  lr_d1_q, lr_d1_d, lr_d2_q, lr_d2_d;
    logic [WORDSIZE-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [WORDSIZE-1:0]   left_hold_q, left_hold_d;
    logic [WORDSIZE-1:0]   right_hold_q, right_hold_d;
    logic                  pair_ready_q, pair_ready_d;
    logic                  write_en_q, write_en_d;
    logic [WORDSIZE-1:0]   data_left_q, data_left_d;
    logic [WORDSIZE-1:0]   data_right_q, data_right_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  bclk_ev;
    logic                  new_slot;
    logic [WORDSIZE-1:0]   sd_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            sd_s1_q   <= 1'b0;
            sd_s2_q   <= 1'b0;
        end else begin
            bclk_s1_q <= bus.i2s_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lr_s1_q   <= bus.i2s_lrclk;
            lr_s2_q   <= lr_s1_q;
            sd_s1_q   <= bus.i2s_sdata;
            sd_s2_q   <= sd_s1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        lr_d1_d      = lr_d1_q;
        lr_d2_d      = lr_d2_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        pair_ready_d = 1'b0;
        write_en_d   = 1'b0;
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        overflow_d   = overflow_q;
        drop_d       = drop_q;

        bclk_ev  = bclk_s2_q & ~bclk_s3_q;
        // Evaluated on the pre-update history: the bit sampled now belongs to lr_d1.
        new_slot = lr_d1_q ^ lr_d2_q;
        sd_msb   = '0;
        sd_msb[WORDSIZE-1] = sd_s2_q;

        if (bclk_ev) begin
            lr_d1_d = lr_s2_q;
            lr_d2_d = lr_d1_q;
        end

        if (!bus.enable) begin
            state_d  = SYNC;
            bitcnt_d = '0;
        end else if (bclk_ev) begin
            if (new_slot) begin
                shift_d  = sd_msb;
                bitcnt_d = CNT_W'(1);
            end else if (bitcnt_q < CNT_MAX) begin
                shift_d  = shift_q | (sd_msb >> bitcnt_q);
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end

            // A new slot closes the one that just ended, carrying channel lr_d2.
            if (new_slot) begin
                unique case (state_q)
                    SYNC:    if (!lr_d1_q) state_d = LEFT;
                    LEFT: begin
                        left_hold_d = shift_q;
                        state_d     = RIGHT;
                    end
                    RIGHT: begin
                        right_hold_d = shift_q;
                        pair_ready_d = 1'b1;
                        state_d      = LEFT;
                    end
                    default: state_d = SYNC;
                endcase
            end
        end

        if (pair_ready_q && bus.enable) begin
            if (!bus.fifo_full) begin
                write_en_d   = 1'b1;
                data_left_d  = left_hold_q;
                data_right_d = right_hold_q;
            end else begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            lr_d1_q      <= 1'b0;
            lr_d2_q      <= 1'b0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            pair_ready_q <= 1'b0;
            write_en_q   <= 1'b0;
            data_left_q  <= '0;
            data_right_q <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            lr_d1_q      <= lr_d1_d;
            lr_d2_q      <= lr_d2_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            pair_ready_q <= pair_ready_d;
            write_en_q   <= write_en_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.write_en       = write_en_q;
    assign bus.data_left_out  = data_left_q;
    assign bus.data_right_out = data_right_q;
    assign bus.overflow       = overflow_q;
    assign bus.drop_count     = drop_q;
    assign bus.locked         = (state_q != SYNC);

endmodule
